luma_conv_arbiter: RTL and testbench

// - Shares one RGB->luma converter between NUM_REQ pixel sources using round-robin arbitration.
// - Each source presents 24-bit RGB with a valid/ready handshake.
// - The arbiter registers the winning pixel into the converter and tags it with the requester ID.
// - It collects the luma result into a small result FIFO and returns it with its ID over a valid/ready stream.
// - Sits between the camera/pixel-unpack stages and downstream luma consumers.

---
 rtl/luma_conv_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_luma_conv_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/luma_conv_arbiter.sv
// luma_conv_arbiter: round-robin share of one registered RGB->luma converter between NUM_REQ pixel sources.
// Latency: accept edge E0 -> result at FIFO head after edge E0+CONV_LAT+1 (FIFO empty), 1 pixel/clk sustained.
// Backpressure: grants stop once tag-pipe + FIFO occupancy reaches FIFO_DEPTH; only a pop frees credit.
// Optional stats: define LUMA_ARB_STATS_EN to add stall_count_out.

// Show-ahead result FIFO; head is presented combinationally, zero while empty.
module luma_conv_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_vld = (count != '0);
    assign do_pop   = head_vld & pop_rdy;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push  = push_vld & ((count != CNT_W'(DEPTH)) | do_pop);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    // Storage array: written on push, no reset needed since the head is masked while empty.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module luma_conv_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int CONV_LAT   = 1,
    parameter int FIFO_DEPTH = CONV_LAT + 3
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    input  logic [24*NUM_REQ-1:0]  req_rgb_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    output logic [7:0]             conv_r_out,
    output logic [7:0]             conv_g_out,
    output logic [7:0]             conv_b_out,
    input  logic [7:0]             conv_y_in,
    output logic                   y_valid_out,
    output logic [7:0]             y_out,
    output logic [ID_W-1:0]        y_id_out,
    input  logic                   y_ready_in
`ifdef LUMA_ARB_STATS_EN
    ,
    output logic [15:0]            stall_count_out
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      y;
    } res_t;

    tag_t [CONV_LAT:0]       tag_pipe;
    logic [ID_W-1:0]         rr_ptr;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic                    credit_ok;
    logic [2*NUM_REQ-1:0]    rot_vld;
    logic                    found;
    logic [ID_W:0]           id_sum;
    logic [ID_W-1:0]         grant_id;
    logic [NUM_REQ-1:0]      grant;
    logic                    hs_vld;
    logic [23:0]             sel_dat;
    res_t                    push_dat;
    res_t                    head_dat;
    logic                    head_vld;

    // Count live tags in the converter pipe; these already hold a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int k = 0; k <= CONV_LAT; k++) begin
            inflight = inflight + CNT_W'(tag_pipe[k].vld);
        end
    end

    // Credit uses registered occupancy only, so a pop frees a slot one cycle later.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);

    // Round-robin pick: rotate valids so the RR pointer sits at bit 0, take the lowest set bit.
    always_comb begin
        rot_vld  = {req_valid_in, req_valid_in} >> rr_ptr;
        found    = 1'b0;
        id_sum   = '0;
        grant_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot_vld[k]) begin
                found  = 1'b1;
                id_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            end
        end
        if (id_sum >= (ID_W + 1)'(NUM_REQ)) begin
            id_sum = id_sum - (ID_W + 1)'(NUM_REQ);
        end
        grant_id = id_sum[ID_W-1:0];
        grant    = '0;
        if (found && credit_ok && !rst_in) begin
            grant = NUM_REQ'(1) << grant_id;
        end
    end

    assign req_ready_out = grant;
    assign hs_vld        = |grant;

    // Mux the granted requester's pixel.
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_dat = req_rgb_in[24*k +: 24];
            end
        end
    end

    // Register the winning pixel, advance the RR pointer past the winner, shift the tag pipe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            conv_r_out <= '0;
            conv_g_out <= '0;
            conv_b_out <= '0;
            rr_ptr     <= '0;
            tag_pipe   <= '0;
        end else begin
            tag_pipe[0] <= {hs_vld, grant_id};
            for (int k = 1; k <= CONV_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
            if (hs_vld) begin
                conv_r_out <= sel_dat[23:16];
                conv_g_out <= sel_dat[15:8];
                conv_b_out <= sel_dat[7:0];
                rr_ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // The last tag stage lines up with the converter's registered luma.
    assign push_dat.id = tag_pipe[CONV_LAT].id;
    assign push_dat.y  = conv_y_in;

    luma_conv_fifo #(
        .WIDTH (ID_W + 8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_res_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push_vld (tag_pipe[CONV_LAT].vld),
        .push_dat (push_dat),
        .pop_rdy  (y_ready_in),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign y_valid_out = head_vld;
    assign y_out       = head_dat.y;
    assign y_id_out    = head_dat.id;

`ifdef LUMA_ARB_STATS_EN
    logic [15:0] stall_cnt;

    // Saturating count of cycles where someone wants in but credit is exhausted.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stall_cnt <= '0;
        end else if ((|req_valid_in) && !hs_vld && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_count_out = stall_cnt;
`endif
endmodule

// File: tb/tb_luma_conv_arbiter.sv
// Directed bench for luma_conv_arbiter with a one-cycle luma converter model (77R+149G+29B)>>8.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Covers reset, single pixel latency, round-robin order, streaming, backpressure, async reset, stats.
module tb_luma_conv_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_valid_in;
    logic [95:0] req_rgb_in;
    logic [3:0]  req_ready_out;
    logic [7:0]  conv_r_out;
    logic [7:0]  conv_g_out;
    logic [7:0]  conv_b_out;
    logic [7:0]  conv_y_in = 8'd0;
    logic        y_valid_out;
    logic [7:0]  y_out;
    logic [1:0]  y_id_out;
    logic        y_ready_in;
`ifdef LUMA_ARB_STATS_EN
    logic [15:0] stall_count_out;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_y [4];

    always #5 clk_in = ~clk_in;

    luma_conv_arbiter #(
        .NUM_REQ    (4),
        .ID_W       (2),
        .CONV_LAT   (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_rgb_in    (req_rgb_in),
        .req_ready_out (req_ready_out),
        .conv_r_out    (conv_r_out),
        .conv_g_out    (conv_g_out),
        .conv_b_out    (conv_b_out),
        .conv_y_in     (conv_y_in),
        .y_valid_out   (y_valid_out),
        .y_out         (y_out),
        .y_id_out      (y_id_out),
        .y_ready_in    (y_ready_in)
`ifdef LUMA_ARB_STATS_EN
        ,
        .stall_count_out (stall_count_out)
`endif
    );

    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int s;
        s = 77 * int'(r) + 149 * int'(g) + 29 * int'(b);
        return 8'(s >> 8);
    endfunction

    // Converter model: one register stage from the arbiter's pixel outputs.
    always_ff @(posedge clk_in) begin
        conv_y_in <= luma(conv_r_out, conv_g_out, conv_b_out);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        exp_y[0] = 8'd76;   // FF0000
        exp_y[1] = 8'd148;  // 00FF00
        exp_y[2] = 8'd28;   // 0000FF
        exp_y[3] = 8'd254;  // FFFFFF

        rst_in       = 1'b1;
        req_valid_in = '0;
        req_rgb_in   = '0;
        y_ready_in   = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready_out), 32'h0);
        chk("rst_yvld",  32'(y_valid_out),   32'h0);
        chk("rst_y",     32'(y_out),         32'h0);
        chk("rst_id",    32'(y_id_out),      32'h0);
        chk("rst_conv",  32'({conv_r_out, conv_g_out, conv_b_out}), 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Single white pixel from requester 2
        @(negedge clk_in);
        y_ready_in        = 1'b1;
        req_rgb_in[71:48] = 24'hFFFFFF;
        req_valid_in      = 4'b0100;
        #1 chk("single_grant", 32'(req_ready_out), 32'h4);
        @(negedge clk_in);
        req_valid_in = '0;
        #1 chk("single_conv_r", 32'(conv_r_out), 32'hFF);
        chk("single_lat1", 32'(y_valid_out), 32'h0);
        @(negedge clk_in);
        #1 chk("single_lat2", 32'(y_valid_out), 32'h0);
        @(negedge clk_in);
        #1 chk("single_yvld", 32'(y_valid_out), 32'h1);
        chk("single_y",  32'(y_out),    32'd254);
        chk("single_id", 32'(y_id_out), 32'd2);
        @(negedge clk_in);
        #1 chk("single_popped", 32'(y_valid_out), 32'h0);

        // Move the RR pointer to 2 via requester 1, then requesters 1 and 3 contend
        req_valid_in = 4'b0010;
        #1 chk("rr_setup", 32'(req_ready_out), 32'h2);
        @(negedge clk_in);
        req_valid_in = 4'b1010;
        #1 chk("rr_first3",  32'(req_ready_out), 32'h8);
        @(negedge clk_in);
        #1 chk("rr_then1",   32'(req_ready_out), 32'h2);
        @(negedge clk_in);
        #1 chk("rr_then3",   32'(req_ready_out), 32'h8);
        @(negedge clk_in);
        req_valid_in = '0;
        repeat (4) @(negedge clk_in);
        #1 chk("rr_drained", 32'(y_valid_out), 32'h0);

        // All four requesters valid every cycle, downstream always ready
        @(negedge clk_in);
        req_rgb_in   = {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};
        req_valid_in = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1 chk("all_grant", 32'(req_ready_out), 32'(4'b0001 << (i % 4)));
            if (i >= 3) begin
                chk("all_yvld", 32'(y_valid_out), 32'h1);
                chk("all_id",   32'(y_id_out),    32'((i - 3) % 4));
                chk("all_y",    32'(y_out),       32'(exp_y[(i - 3) % 4]));
            end
            @(negedge clk_in);
        end
        req_valid_in = '0;
        repeat (5) @(negedge clk_in);
        #1 chk("all_drained", 32'(y_valid_out), 32'h0);

        // Backpressure: requester 0 streams red with downstream stalled
        @(negedge clk_in);
        y_ready_in   = 1'b0;
        req_valid_in = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            #1 chk("bp_ready", 32'(req_ready_out), (i < 4) ? 32'h1 : 32'h0);
            @(negedge clk_in);
        end
        y_ready_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1 chk("bp_ready_resume", 32'(req_ready_out), (j == 0) ? 32'h0 : 32'h1);
            chk("bp_yvld", 32'(y_valid_out), 32'h1);
            chk("bp_y",    32'(y_out),       32'd76);
            chk("bp_id",   32'(y_id_out),    32'd0);
            @(negedge clk_in);
        end

        // Asynchronous reset with pixels in the tag pipe and FIFO
        rst_in = 1'b1;
        #1 chk("arst_ready", 32'(req_ready_out), 32'h0);
        chk("arst_yvld", 32'(y_valid_out), 32'h0);
        chk("arst_y",    32'(y_out),       32'h0);
        chk("arst_id",   32'(y_id_out),    32'h0);
        chk("arst_conv", 32'({conv_r_out, conv_g_out, conv_b_out}), 32'h0);
        req_valid_in = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("arst_no_stale", 32'(y_valid_out), 32'h0);
            @(negedge clk_in);
        end
        req_valid_in = 4'b1111;
        #1 chk("arst_first_grant", 32'(req_ready_out), 32'h1);
        @(negedge clk_in);
        req_valid_in = '0;
        repeat (4) @(negedge clk_in);
        #1 chk("arst_drained", 32'(y_valid_out), 32'h0);

`ifdef LUMA_ARB_STATS_EN
        // Fill the FIFO, then hold requester 0 valid for 10 credit-starved cycles
        @(negedge clk_in);
        y_ready_in   = 1'b0;
        req_valid_in = 4'b0001;
        repeat (14) @(negedge clk_in);
        req_valid_in = '0;
        #1 chk("stall_count", 32'(stall_count_out), 32'd10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
